// File: rtl/cache_pkg.sv
// Shared types and constants for the cache refill memory model.
// Holds the FSM encoding, word geometry and default data pattern.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int WORD_OFF_W = $clog2(WORD_BYTES);

    localparam int DEF_WORDS_PER_BLOCK = 4;
    localparam int DEF_IDX_W = $clog2(DEF_WORDS_PER_BLOCK);
    localparam int DEF_OFF_W = DEF_IDX_W + WORD_OFF_W;

    localparam logic [31:0] DEF_PATTERN = 32'hDEAD_BEEF;

    function automatic int idx_w(input int wpb);
        return $clog2(wpb);
    endfunction

    function automatic int off_w(input int wpb);
        return $clog2(wpb) + WORD_OFF_W;
    endfunction

endpackage

// File: rtl/cache_refill_memory_if.sv
// Request/response bundle between the cache and the refill memory.
// The cache is the master; the memory model is the slave.
interface cache_refill_memory_if
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = DEF_IDX_W
);
    logic                  req_valid;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic                  req_ready;
    logic                  resp_valid;
    logic [ADDR_WIDTH-1:0] resp_addr;
    logic [DATA_WIDTH-1:0] resp_data;
    logic [IDX_W-1:0]      resp_word;
    logic                  resp_last;

    modport master (
        output req_valid, req_addr,
        input  req_ready, resp_valid, resp_addr,
        input  resp_data, resp_word, resp_last
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, resp_valid, resp_addr,
        output resp_data, resp_word, resp_last
    );
endinterface

// File: rtl/refill_beat_gen.sv
// Critical-word-first beat sequencer for one block refill.
// Word index wraps inside the block, so addresses never leave it.
module refill_beat_gen
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
    parameter logic [DATA_WIDTH-1:0] PATTERN = DEF_PATTERN,
    localparam int IDX_W          = idx_w(WORDS_PER_BLOCK)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_adv,
    input  logic [ADDR_WIDTH-1:0] i_base,
    input  logic [IDX_W-1:0]      i_crit,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [IDX_W-1:0]      o_word,
    output logic                  o_last
);
    logic [IDX_W-1:0]      r_beat;
    logic [IDX_W-1:0]      r_word;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_last;

    logic [IDX_W-1:0]      w_beat;
    logic [IDX_W-1:0]      w_word;
    logic [ADDR_WIDTH-1:0] w_addr;

    // Base has its offset bits cleared, so OR is the carry-free add.
    assign w_beat = i_start ? '0 : r_beat + IDX_W'(1);
    assign w_word = i_start ? i_crit : r_word + IDX_W'(1);
    assign w_addr = i_base | (ADDR_WIDTH'(w_word) << WORD_OFF_W);

    // Register each beat; last drops once the burst stops advancing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat <= '0;
            r_word <= '0;
            r_addr <= '0;
            r_data <= '0;
            r_last <= 1'b0;
        end else if (i_start || i_adv) begin
            r_beat <= w_beat;
            r_word <= w_word;
            r_addr <= w_addr;
            r_data <= DATA_WIDTH'(w_addr) ^ PATTERN;
            r_last <= (w_beat == '1);
        end else begin
            r_last <= 1'b0;
        end
    end

    assign o_addr = r_addr;
    assign o_data = r_data;
    assign o_word = r_word;
    assign o_last = r_last;
endmodule

// File: rtl/cache_refill_memory.sv
// Main-memory model behind the direct-mapped cache.
// Fixed-latency block refill, critical word first, miss counting.
module cache_refill_memory
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
    parameter int LATENCY         = 8,
    parameter logic [DATA_WIDTH-1:0] PATTERN = DEF_PATTERN
) (
    input  logic                 clk,
    input  logic                 rst,
    cache_refill_memory_if.slave bus,
    output logic [31:0]          miss_count
);
    localparam int IDX_W = idx_w(WORDS_PER_BLOCK);
    localparam int OFF_W = off_w(WORDS_PER_BLOCK);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [ADDR_WIDTH-1:0] BASE_MASK =
        {ADDR_WIDTH{1'b1}} << OFF_W;

    state_t                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [IDX_W-1:0]      r_crit;
    logic                  r_ready;
    logic                  r_valid;
    logic [31:0]           r_miss;

    logic                  w_start;
    logic                  w_adv;
    logic                  w_last;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [IDX_W-1:0]      w_word;

    assign w_start = (r_state == WAIT) && (r_cnt == '0);
    assign w_adv   = (r_state == BURST) && !w_last;

    // Request FSM: accept in IDLE, count down latency, run the burst.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_base  <= '0;
            r_crit  <= '0;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_miss  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_base  <= bus.req_addr & BASE_MASK;
                        r_crit  <= bus.req_addr[OFF_W-1:WORD_OFF_W];
                        r_cnt   <= CNT_W'(LATENCY - 1);
                        r_miss  <= r_miss + 32'd1;
                        r_ready <= 1'b0;
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt == '0) begin
                        r_state <= BURST;
                        r_valid <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                BURST: begin
                    if (w_last) begin
                        r_state <= IDLE;
                        r_valid <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    refill_beat_gen #(
        .ADDR_WIDTH      (ADDR_WIDTH),
        .DATA_WIDTH      (DATA_WIDTH),
        .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
        .PATTERN         (PATTERN)
    ) u_beat (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_adv   (w_adv),
        .i_base  (r_base),
        .i_crit  (r_crit),
        .o_addr  (w_addr),
        .o_data  (w_data),
        .o_word  (w_word),
        .o_last  (w_last)
    );

    assign bus.req_ready  = r_ready;
    assign bus.resp_valid = r_valid;
    assign bus.resp_addr  = w_addr;
    assign bus.resp_data  = w_data;
    assign bus.resp_word  = w_word;
    assign bus.resp_last  = w_last;
    assign miss_count     = r_miss;
endmodule

// File: tb/tb_cache_refill_memory.sv
// Directed-plus-random bench for cache_refill_memory.
// Two instances: default geometry, and LATENCY=1 with 8-word blocks.
module tb_cache_refill_memory;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_refill_memory_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .IDX_W(2)) b0 ();
    cache_refill_memory_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .IDX_W(3)) b1 ();

    logic [31:0] mc0;
    logic [31:0] mc1;

    cache_refill_memory #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .WORDS_PER_BLOCK(4),
        .LATENCY(8), .PATTERN(32'hDEAD_BEEF)
    ) d0 (
        .clk(clk), .rst(rst), .bus(b0.slave), .miss_count(mc0)
    );

    cache_refill_memory #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .WORDS_PER_BLOCK(8),
        .LATENCY(1), .PATTERN(32'hDEAD_BEEF)
    ) d1 (
        .clk(clk), .rst(rst), .bus(b1.slave), .miss_count(mc1)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int unsigned em [2];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: block base plus wrapped word offset, computed arithmetically.
    function automatic logic [31:0] exp_addr(input logic [31:0] a,
                                             input int w, input int i);
        logic [31:0] base;
        int crit;
        base = a - (a % (4 * w));
        crit = int'((a / 4) % w);
        return base + 32'(4 * ((crit + i) % w));
    endfunction

    task automatic drive(input int u, input logic v, input logic [31:0] a);
        if (u == 0) begin
            b0.req_valid = v;
            b0.req_addr  = a;
        end else begin
            b1.req_valid = v;
            b1.req_addr  = a;
        end
    endtask

    task automatic samp(input int u, output logic v, output logic r,
                        output logic l, output logic [31:0] ad,
                        output logic [31:0] da, output logic [31:0] wd,
                        output logic [31:0] mc);
        if (u == 0) begin
            v = b0.resp_valid; r = b0.req_ready; l = b0.resp_last;
            ad = b0.resp_addr; da = b0.resp_data;
            wd = 32'(b0.resp_word); mc = mc0;
        end else begin
            v = b1.resp_valid; r = b1.req_ready; l = b1.resp_last;
            ad = b1.resp_addr; da = b1.resp_data;
            wd = 32'(b1.resp_word); mc = mc1;
        end
    endtask

    task automatic run_req(input int u, input logic [31:0] a);
        int w;
        int lat;
        int budget;
        logic v, r, l;
        logic [31:0] ad, da, wd, mc, ea;
        w   = (u == 0) ? 4 : 8;
        lat = (u == 0) ? 8 : 1;
        drive(u, 1'b1, a);
        samp(u, v, r, l, ad, da, wd, mc);
        budget = 0;
        while (!r && budget < 50) begin
            tick();
            samp(u, v, r, l, ad, da, wd, mc);
            budget++;
        end
        if (!r) begin
            chk("ready_timeout", 32'(r), 32'd1);
            drive(u, 1'b0, '0);
            return;
        end
        tick();
        em[u]++;
        drive(u, 1'($urandom), $urandom);
        samp(u, v, r, l, ad, da, wd, mc);
        chk("acc_ready", 32'(r), 32'd0);
        chk("acc_miss", mc, em[u]);
        for (int c = 1; c < lat; c++) begin
            tick();
            drive(u, 1'($urandom), $urandom);
            samp(u, v, r, l, ad, da, wd, mc);
            chk("wait_valid", 32'(v), 32'd0);
        end
        for (int i = 0; i < w; i++) begin
            tick();
            drive(u, 1'($urandom), $urandom);
            samp(u, v, r, l, ad, da, wd, mc);
            ea = exp_addr(a, w, i);
            chk("beat_valid", 32'(v), 32'd1);
            chk("beat_addr", ad, ea);
            chk("beat_data", da, ea ^ 32'hDEAD_BEEF);
            chk("beat_word", wd, (ea / 4) % 32'(w));
            chk("beat_last", 32'(l), 32'(i == w - 1));
        end
        tick();
        drive(u, 1'b0, '0);
        samp(u, v, r, l, ad, da, wd, mc);
        chk("end_valid", 32'(v), 32'd0);
        chk("end_last", 32'(l), 32'd0);
        chk("end_ready", 32'(r), 32'd1);
        chk("end_miss", mc, em[u]);
    endtask

    initial begin
        logic v, r, l;
        logic [31:0] ad, da, wd, mc, ra;
        int p;
        em[0] = 0;
        em[1] = 0;
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        rst = 1'b1;
        repeat (3) tick();
        samp(0, v, r, l, ad, da, wd, mc);
        chk("rst_ready", 32'(r), 32'd1);
        chk("rst_valid", 32'(v), 32'd0);
        chk("rst_miss", mc, 32'd0);
        chk("rst_addr", ad, 32'd0);
        chk("rst_data", da, 32'd0);
        chk("rst_word", wd, 32'd0);
        chk("rst_last", 32'(l), 32'd0);
        rst = 1'b0;
        tick();

        run_req(0, 32'h1fff_ff17);
        chk("const_data", exp_addr(32'h1fff_ff17, 4, 0) ^ 32'hDEAD_BEEF,
            32'hC152_41FB);
        run_req(0, 32'h0000_0000);
        repeat (6) run_req(0, $urandom);

        drive(0, 1'b1, 32'h40);
        for (int c = 0; c < 39; c++) begin
            tick();
            samp(0, v, r, l, ad, da, wd, mc);
            p = c % 13;
            chk("hold_valid", 32'(v), 32'(p >= 8 && p <= 11));
            chk("hold_ready", 32'(r), 32'(p == 12));
            chk("hold_miss", mc, em[0] + 32'(c / 13) + 32'd1);
            if (p >= 8 && p <= 11)
                chk("hold_addr", ad, exp_addr(32'h40, 4, p - 8));
        end
        drive(0, 1'b0, '0);
        em[0] += 3;
        tick();
        samp(0, v, r, l, ad, da, wd, mc);
        chk("hold_stop_miss", mc, em[0]);

        ra = $urandom;
        drive(0, 1'b1, ra);
        tick();
        drive(0, 1'b0, '0);
        repeat (9) tick();
        samp(0, v, r, l, ad, da, wd, mc);
        chk("pre_rst_valid", 32'(v), 32'd1);
        chk("pre_rst_addr", ad, exp_addr(ra, 4, 1));
        rst = 1'b1;
        tick();
        em[0] = 0;
        em[1] = 0;
        samp(0, v, r, l, ad, da, wd, mc);
        chk("mid_rst_valid", 32'(v), 32'd0);
        chk("mid_rst_ready", 32'(r), 32'd1);
        chk("mid_rst_miss", mc, 32'd0);
        chk("mid_rst_last", 32'(l), 32'd0);
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            samp(0, v, r, l, ad, da, wd, mc);
            chk("post_rst_valid", 32'(v), 32'd0);
        end
        run_req(0, $urandom);

        run_req(1, 32'h0000_003C);
        repeat (3) run_req(1, $urandom);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cache_refill_memory.md
Name: cache_refill_memory

Overview:
- Backing main-memory model directly downstream of the direct-mapped cache (`main`).
- Accepts one block-refill request per cache miss and waits a fixed access latency.
- Returns the full cache block as a critical-word-first burst, one word per cycle, and counts serviced misses.
- Contents are a deterministic function of address, so refill data can be checked without a memory image.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- DATA_WIDTH, 32, word width (fixed at 32 in this revision).
- WORDS_PER_BLOCK, 4, words per cache block; power of 2, >= 2.
- LATENCY, 8, cycles from request acceptance to the first beat; >= 1.
- PATTERN, 32'hDEAD_BEEF, XOR mask used to generate word contents.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  cache asserts on a miss; held until accepted.
- req_addr  in  ADDR_WIDTH  miss byte address; sampled on acceptance.
- req_ready  out  1  high only in IDLE.
- resp_valid  out  1  one beat of refill data is valid.
- resp_addr  out  ADDR_WIDTH  word-aligned byte address of the current beat.
- resp_data  out  DATA_WIDTH  equals resp_addr ^ PATTERN.
- resp_word  out  log2(WORDS_PER_BLOCK)  word index within the block for this beat.
- resp_last  out  1  high on the final beat of the burst.
- miss_count  out  32  number of requests accepted since reset.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (`clk`, `rst`).
- Reset values:
  - req_ready=1 after reset.
  - resp_valid=0, resp_last=0, resp_addr=0, resp_data=0, resp_word=0, miss_count=0.
  - FSM enters IDLE.
- Reset mid-operation: any wait or burst in progress is aborted. No further beats appear; the next request is accepted only after rst deasserts.
- Acceptance: a request is accepted on a rising edge where req_valid & req_ready is high.
  - Latch base = req_addr with the low log2(WORDS_PER_BLOCK)+2 bits cleared.
  - Latch crit = req_addr[log2(WORDS_PER_BLOCK)+1:2].
  - Load the latency counter with LATENCY-1.
  - Increment miss_count; it wraps at 2^32.
- FSM states and transitions:
  - IDLE: req_ready=1. On acceptance -> WAIT.
  - WAIT: req_ready=0. Counter decrements each cycle. When the counter is 0 -> BURST, with the first beat registered on that same edge.
  - BURST: emits WORDS_PER_BLOCK consecutive beats, resp_valid=1 on every cycle.
    - Beat i has word index (crit+i) mod WORDS_PER_BLOCK, wrapping within the block.
    - resp_addr = base + 4*index.
    - resp_last=1 on beat WORDS_PER_BLOCK-1.
    - After the last beat -> IDLE with resp_valid=0.
- Timing:
  - Request accepted at edge k: the first beat is visible after edge k+LATENCY; the last after edge k+LATENCY+WORDS_PER_BLOCK-1.
  - req_ready returns high after edge k+LATENCY+WORDS_PER_BLOCK. Back-to-back requests can therefore be accepted no faster than every LATENCY+WORDS_PER_BLOCK+1 cycles.
- Flow control:
  - No response backpressure: the cache must consume every beat.
  - req_valid asserted outside IDLE is ignored and not counted.
  - Changes to req_addr while req_ready=0 have no effect.
- LATENCY=1: WAIT lasts exactly one cycle; the counter starts at 0.
- Address wrap: base+4*index never crosses a block boundary; arithmetic is ADDR_WIDTH bits with no carry-out.

Decomposition:
- Shared package `cache_pkg`:
  - FSM state enum {IDLE, WAIT, BURST}.
  - WORD_BYTES=4.
  - Index-width and offset-width localparams derived from WORDS_PER_BLOCK.
  - PATTERN default.
- One sub-module: `refill_beat_gen`. It takes base, crit and a start pulse, and produces the indexed beat sequence (resp_addr, resp_word, resp_last). The top level keeps the FSM, latency counter and miss_count.

Test Plan:
- Reset with rst=1 for 3 cycles -> req_ready=1, resp_valid=0, miss_count=0.
- Request req_addr=32'h1fffff17 at edge k:
  - Beats after edges k+8..k+11 carry resp_addr 1fffff14, 1fffff18, 1fffff1c, 1fffff10 and resp_word 1, 2, 3, 0.
  - First resp_data = 32'hC15241FB.
  - resp_last only on the 4th beat; miss_count=1.
- Request at 32'h00000000 -> beats 0x0, 0x4, 0x8, 0xC with resp_data DEADBEEF, DEADBEEB, DEADBEE7, DEADBEE3.
- req_valid held high continuously with address 0x40 -> accepts only at the expected points, every 13 cycles. miss_count increments once per acceptance; no beats overlap.
- Assert rst during beat 2 of a burst -> resp_valid=0 after the next edge, no further beats, miss_count=0, and a new request is accepted normally afterwards.
- LATENCY=1, WORDS_PER_BLOCK=8, req_addr=0x3C -> first beat visible one edge after acceptance with resp_addr 0x3C, resp_word 7; next beat 0x20 (wrap).
